// File: rtl/riscv_dmem_wait.sv
// riscv_dmem_wait: multi-cycle data memory with req/ack handshake, programmable wait
// states, byte-strobe writes and out-of-range error reporting.
module riscv_dmem_wait #(
    parameter int XLEN     = 32,
    parameter int ADDR_BIT = 12,
    parameter int WAIT     = 2
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_dmem_req,
    input  logic            i_dmem_wr_en,
    input  logic [XLEN-1:0] i_dmem_addr,
    input  logic [3:0]      i_dmem_strb,
    input  logic [XLEN-1:0] i_dmem_wr_data,
    output logic [XLEN-1:0] o_dmem_rd_data,
    output logic            o_dmem_ack,
    output logic            o_dmem_err,
    output logic            o_dmem_busy
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam int DEPTH = 1 << (ADDR_BIT - 2);

    logic [XLEN-1:0]     mem_q [DEPTH];
    logic [1:0]          state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                wr_q;
    logic [XLEN-3:0]     addr_q;
    logic [3:0]          strb_q;
    logic [XLEN-1:0]     wdata_q;
    logic [XLEN-1:0]     rd_q;
    logic                ack_q, err_q;
    logic                oob;
    logic                access;
    logic [ADDR_BIT-3:0] idx;
    logic                unused_addr;

    // addr_q holds the word address; byte-offset bits are dropped on capture
    assign unused_addr = ^i_dmem_addr[1:0];
    assign oob         = |(addr_q >> (ADDR_BIT - 2));
    assign idx         = addr_q[ADDR_BIT-3:0];
    assign access      = state_q == S_ACCESS;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (i_dmem_req) begin
                cnt_d   = 4'(WAIT);
                state_d = (WAIT == 0) ? S_ACCESS : S_WAIT;
            end
            S_WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? S_ACCESS : S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= access;
            err_q   <= access && oob;
            if (access && !wr_q)
                rd_q <= oob ? '0 : mem_q[idx];
        end
    end

    always_ff @(posedge i_clk) begin
        if (state_q == S_IDLE && i_dmem_req) begin
            wr_q    <= i_dmem_wr_en;
            addr_q  <= i_dmem_addr[XLEN-1:2];
            strb_q  <= i_dmem_strb;
            wdata_q <= i_dmem_wr_data;
        end
    end

    // storage has no reset; a reset coinciding with ACCESS suppresses the write
    always_ff @(posedge i_clk) begin
        if (i_rstn && access && wr_q && !oob)
            for (int b = 0; b < 4; b++)
                if (strb_q[b])
                    mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
    end

    assign o_dmem_rd_data = rd_q;
    assign o_dmem_ack     = ack_q;
    assign o_dmem_err     = err_q;
    assign o_dmem_busy    = state_q != S_IDLE;
endmodule

// File: tb/tb_riscv_dmem_wait.sv
// tb_riscv_dmem_wait: scoreboard bench over three instances (WAIT = 2, 0, 4).
module tb_riscv_dmem_wait;
    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
        int          tag;
    } exp_t;

    logic        clk = 1'b0;
    logic [2:0]  rstn = 3'b000;
    logic [2:0]  req = 3'b000;
    logic        wr_en = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  strb = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rd_o [3];
    logic [2:0]  ack_o, err_o, busy_o;

    exp_t sb [3][$];
    int   waits [3] = '{2, 0, 4};
    int   cyc = 0;
    int   tag_n = 0;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    riscv_dmem_wait #(.WAIT(2)) u_w2 (
        .i_clk(clk), .i_rstn(rstn[0]), .i_dmem_req(req[0]), .i_dmem_wr_en(wr_en),
        .i_dmem_addr(addr), .i_dmem_strb(strb), .i_dmem_wr_data(wdata),
        .o_dmem_rd_data(rd_o[0]), .o_dmem_ack(ack_o[0]), .o_dmem_err(err_o[0]),
        .o_dmem_busy(busy_o[0]));
    riscv_dmem_wait #(.WAIT(0)) u_w0 (
        .i_clk(clk), .i_rstn(rstn[1]), .i_dmem_req(req[1]), .i_dmem_wr_en(wr_en),
        .i_dmem_addr(addr), .i_dmem_strb(strb), .i_dmem_wr_data(wdata),
        .o_dmem_rd_data(rd_o[1]), .o_dmem_ack(ack_o[1]), .o_dmem_err(err_o[1]),
        .o_dmem_busy(busy_o[1]));
    riscv_dmem_wait #(.WAIT(4)) u_w4 (
        .i_clk(clk), .i_rstn(rstn[2]), .i_dmem_req(req[2]), .i_dmem_wr_en(wr_en),
        .i_dmem_addr(addr), .i_dmem_strb(strb), .i_dmem_wr_data(wdata),
        .o_dmem_rd_data(rd_o[2]), .o_dmem_ack(ack_o[2]), .o_dmem_err(err_o[2]),
        .o_dmem_busy(busy_o[2]));

    // Monitor: every ack must match the oldest expectation of its instance.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ack_o[k]) begin
                compared++;
                if (sb[k].size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_ack inst%0d cyc=%0d rd=%h err=%b", k, cyc, rd_o[k], err_o[k]);
                end else begin
                    exp_t e;
                    e = sb[k].pop_front();
                    if (rd_o[k] !== e.rd || err_o[k] !== e.err || cyc != e.cyc) begin
                        mismatched++;
                        $display("FAIL txn%0d inst%0d: got rd=%h err=%b cyc=%0d, want rd=%h err=%b cyc=%0d",
                                 e.tag, k, rd_o[k], err_o[k], cyc, e.rd, e.err, e.cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h, want %h", nm, got, want);
        end
    endtask

    task automatic issue(input int k, input logic wr, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input logic [31:0] erd, input logic eerr,
                         input logic keep);
        exp_t e;
        int n;
        wr_en = wr; addr = a; strb = s; wdata = d; req[k] = 1'b1;
        @(posedge clk); #1;
        e.rd = erd; e.err = eerr; e.cyc = cyc + waits[k] + 1; e.tag = tag_n;
        sb[k].push_back(e);
        tag_n++;
        req[k] = keep;
        chk("busy_after_accept", 32'(busy_o[k]), 32'd1);
        n = 0;
        while (!ack_o[k] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ack_o[k]) begin
            compared++;
            mismatched++;
            $display("FAIL ack_timeout inst%0d: got no ack, want ack within 40 cycles", k);
        end
    endtask

    initial begin
        int c0;
        // Reset held with req asserted: nothing accepted, outputs quiet.
        req[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_ack", 32'(ack_o[0]), 32'd0);
            chk("rst_busy", 32'(busy_o[0]), 32'd0);
            chk("rst_err", 32'(err_o[0]), 32'd0);
            chk("rst_rd", rd_o[0], 32'd0);
        end
        req[0] = 1'b0;
        rstn = 3'b111;
        @(posedge clk); #1;
        chk("post_rst_busy", 32'(busy_o[0]), 32'd0);

        // WAIT=2 write/read, byte strobes, out-of-range
        issue(0, 1, 32'h010, 4'hF, 32'hDEADBEEF, 32'h0, 0, 0);
        issue(0, 0, 32'h010, 4'h0, 32'h0, 32'hDEADBEEF, 0, 0);
        issue(0, 1, 32'h020, 4'hF, 32'h11223344, 32'hDEADBEEF, 0, 0);
        issue(0, 1, 32'h020, 4'b0101, 32'hAABBCCDD, 32'hDEADBEEF, 0, 0);
        issue(0, 0, 32'h020, 4'hF, 32'h0, 32'h11BB33DD, 0, 0);
        issue(0, 1, 32'h000, 4'hF, 32'h0BADF00D, 32'h11BB33DD, 0, 0);
        issue(0, 1, 32'h1000, 4'hF, 32'h5555AAAA, 32'h11BB33DD, 1, 0);
        issue(0, 0, 32'h1000, 4'hF, 32'h0, 32'h0, 1, 0);
        issue(0, 0, 32'h000, 4'hF, 32'h0, 32'h0BADF00D, 0, 0);

        // WAIT=0 back-to-back reads with req held high
        issue(1, 1, 32'h0, 4'hF, 32'd1, 32'h0, 0, 0);
        issue(1, 1, 32'h4, 4'hF, 32'd2, 32'h0, 0, 0);
        issue(1, 1, 32'h8, 4'hF, 32'd3, 32'h0, 0, 0);
        c0 = cyc;
        issue(1, 0, 32'h0, 4'hF, 32'h0, 32'd1, 0, 1);
        issue(1, 0, 32'h4, 4'hF, 32'h0, 32'd2, 0, 1);
        issue(1, 0, 32'h8, 4'hF, 32'h0, 32'd3, 0, 0);
        chk("b2b_span", 32'(cyc - c0), 32'd6);

        // WAIT=4: reset during the second wait cycle aborts the write
        issue(2, 1, 32'h040, 4'hF, 32'h12345678, 32'h0, 0, 0);
        wr_en = 1'b1; addr = 32'h040; strb = 4'hF; wdata = 32'hCAFEF00D; req[2] = 1'b1;
        @(posedge clk); #1;
        req[2] = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy_before", 32'(busy_o[2]), 32'd1);
        rstn[2] = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy_o[2]), 32'd0);
        chk("abort_rd", rd_o[2], 32'd0);
        rstn[2] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        issue(2, 0, 32'h040, 4'hF, 32'h0, 32'h12345678, 0, 0);

        repeat (3) @(posedge clk);
        for (int k = 0; k < 3; k++)
            chk("sb_drained", 32'(sb[k].size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
